// File: rtl/decode_stage.sv
// decode_stage: Y86 decode stage and D->E pipeline register.
// Derives register-file source/destination IDs and resolves operand values.
// It also detects load/use hazards.
// Build option DECODE_FWD_EN: when defined, operands are forwarded from
// in-flight results. When it is undefined, any in-flight write to a needed
// source stalls decode until the value reaches the register file.
module decode_stage #(
    parameter logic [2:0] ESP_ID = 3'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_valid,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [2:0]  f_rA,
    input  logic [2:0]  f_rB,
    input  logic [31:0] f_valC,
    input  logic [31:0] f_valP,
    input  logic        stall_in,
    input  logic        bubble_in,
    output logic [2:0]  srcA,
    output logic [2:0]  srcB,
    input  logic [31:0] rf_valA,
    input  logic [31:0] rf_valB,
    input  logic [2:0]  e_dstE,
    input  logic        e_reqE,
    input  logic [31:0] e_valE,
    input  logic [2:0]  m_dstM,
    input  logic        m_reqM,
    input  logic [31:0] m_valM,
    input  logic [2:0]  M_dstE,
    input  logic        M_reqE,
    input  logic [31:0] M_valE,
    input  logic [2:0]  W_dstM,
    input  logic [2:0]  W_dstE,
    input  logic        W_reqM,
    input  logic        W_reqE,
    input  logic [31:0] W_valM,
    input  logic [31:0] W_valE,
    output logic        d_stall,
    output logic        E_valid,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [31:0] E_valC,
    output logic [31:0] E_valA,
    output logic [31:0] E_valB,
    output logic [2:0]  E_dstE,
    output logic [2:0]  E_dstM,
    output logic [2:0]  E_srcA,
    output logic [2:0]  E_srcB,
    output logic        E_reqE,
    output logic        E_reqM
);
    localparam int unsigned REG_W  = 3;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned WORD_W = 32;

    localparam logic [OP_W-1:0] I_NOP    = 4'h1;
    localparam logic [OP_W-1:0] I_RRMOVL = 4'h2;
    localparam logic [OP_W-1:0] I_IRMOVL = 4'h3;
    localparam logic [OP_W-1:0] I_RMMOVL = 4'h4;
    localparam logic [OP_W-1:0] I_MRMOVL = 4'h5;
    localparam logic [OP_W-1:0] I_OPL    = 4'h6;
    localparam logic [OP_W-1:0] I_JXX    = 4'h7;
    localparam logic [OP_W-1:0] I_CALL   = 4'h8;
    localparam logic [OP_W-1:0] I_RET    = 4'h9;
    localparam logic [OP_W-1:0] I_PUSHL  = 4'hA;
    localparam logic [OP_W-1:0] I_POPL   = 4'hB;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   icode;
        logic [OP_W-1:0]   ifun;
        logic [WORD_W-1:0] valC;
        logic [WORD_W-1:0] valA;
        logic [WORD_W-1:0] valB;
        logic [REG_W-1:0]  dstE;
        logic [REG_W-1:0]  dstM;
        logic [REG_W-1:0]  srcA;
        logic [REG_W-1:0]  srcB;
        logic              reqE;
        logic              reqM;
    } dx_t;

    localparam dx_t DX_BUBBLE = '{1'b0, I_NOP, 4'h0, 32'h0, 32'h0, 32'h0,
                                  3'h0, 3'h0, 3'h0, 3'h0, 1'b0, 1'b0};

    dx_t dx_q, dx_d;

    logic [REG_W-1:0]  dec_srcA, dec_srcB, dec_dstE, dec_dstM;
    logic              need_a, need_b, req_e, req_m;
    logic [WORD_W-1:0] d_valA, d_valB;
    logic              ld_use, hazard;

`ifdef DECODE_FWD_EN
    // Newest in-flight value for a register, falling back to the regfile read.
    function automatic logic [WORD_W-1:0] fwd_pick(input logic [REG_W-1:0] src,
                                                   input logic [WORD_W-1:0] rf_val);
        logic [WORD_W-1:0] val;
        if (e_reqE && e_dstE == src)      val = e_valE;
        else if (m_reqM && m_dstM == src) val = m_valM;
        else if (M_reqE && M_dstE == src) val = M_valE;
        else if (W_reqM && W_dstM == src) val = W_valM;
        else if (W_reqE && W_dstE == src) val = W_valE;
        else                              val = rf_val;
        return val;
    endfunction
`else
    // True when any older instruction still has a pending write to src.
    function automatic logic in_flight(input logic [REG_W-1:0] src);
        return (e_reqE && e_dstE == src) || (m_reqM && m_dstM == src) ||
               (M_reqE && M_dstE == src) || (W_reqM && W_dstM == src) ||
               (W_reqE && W_dstE == src) ||
               (dx_q.valid && dx_q.reqE && dx_q.dstE == src) ||
               (dx_q.valid && dx_q.reqM && dx_q.dstM == src);
    endfunction

    logic unused_fwd_vals;
    assign unused_fwd_vals = ^{e_valE, m_valM, M_valE, W_valM, W_valE};
`endif

    // Register IDs and need/request flags from the fetched instruction.
    always_comb begin
        dec_srcA = '0;
        dec_srcB = '0;
        dec_dstE = '0;
        dec_dstM = '0;
        need_a   = 1'b0;
        need_b   = 1'b0;
        req_e    = 1'b0;
        req_m    = 1'b0;
        case (f_icode)
            I_RRMOVL: begin dec_srcA = f_rA; need_a = 1'b1; dec_dstE = f_rB; req_e = 1'b1; end
            I_IRMOVL: begin dec_dstE = f_rB; req_e = 1'b1; end
            I_RMMOVL: begin dec_srcA = f_rA; need_a = 1'b1; dec_srcB = f_rB; need_b = 1'b1; end
            I_MRMOVL: begin dec_srcB = f_rB; need_b = 1'b1; dec_dstM = f_rA; req_m = 1'b1; end
            I_OPL: begin
                dec_srcA = f_rA; need_a = 1'b1;
                dec_srcB = f_rB; need_b = 1'b1;
                dec_dstE = f_rB; req_e  = 1'b1;
            end
            I_CALL: begin dec_srcB = ESP_ID; need_b = 1'b1; dec_dstE = ESP_ID; req_e = 1'b1; end
            I_RET: begin
                dec_srcA = ESP_ID; need_a = 1'b1;
                dec_srcB = ESP_ID; need_b = 1'b1;
                dec_dstE = ESP_ID; req_e  = 1'b1;
            end
            I_PUSHL: begin
                dec_srcA = f_rA;   need_a = 1'b1;
                dec_srcB = ESP_ID; need_b = 1'b1;
                dec_dstE = ESP_ID; req_e  = 1'b1;
            end
            I_POPL: begin
                dec_srcA = ESP_ID; need_a = 1'b1;
                dec_srcB = ESP_ID; need_b = 1'b1;
                dec_dstE = ESP_ID; req_e  = 1'b1;
                dec_dstM = f_rA;   req_m  = 1'b1;
            end
            default: ;
        endcase
        if (!f_valid) begin
            need_a = 1'b0;
            need_b = 1'b0;
            req_e  = 1'b0;
            req_m  = 1'b0;
        end
    end

    assign srcA = dec_srcA;
    assign srcB = dec_srcB;

    // Operand values; CALL/JXX carry the return/fall-through PC in valA.
    always_comb begin
        d_valA = rf_valA;
        d_valB = rf_valB;
`ifdef DECODE_FWD_EN
        if (need_a) d_valA = fwd_pick(dec_srcA, rf_valA);
        if (need_b) d_valB = fwd_pick(dec_srcB, rf_valB);
`endif
        if (f_icode == I_CALL || f_icode == I_JXX) d_valA = f_valP;
    end

    // Hazard detection: a load in E feeding a needed source, plus any pending write without forwarding.
    always_comb begin
        ld_use = dx_q.valid && dx_q.reqM &&
                 (dx_q.icode == I_MRMOVL || dx_q.icode == I_POPL) &&
                 ((need_a && dx_q.dstM == dec_srcA) || (need_b && dx_q.dstM == dec_srcB));
`ifdef DECODE_FWD_EN
        hazard = ld_use;
`else
        hazard = ld_use || (need_a && in_flight(dec_srcA)) || (need_b && in_flight(dec_srcB));
`endif
    end

    assign d_stall = !reset && hazard;

    // Next D->E register value: hold on stall, bubble on hazard/empty slot, else load.
    always_comb begin
        dx_d = dx_q;
        if (stall_in) begin
            dx_d = dx_q;
        end else if (bubble_in || hazard || !f_valid) begin
            dx_d = DX_BUBBLE;
        end else begin
            dx_d.valid = 1'b1;
            dx_d.icode = f_icode;
            dx_d.ifun  = f_ifun;
            dx_d.valC  = f_valC;
            dx_d.valA  = d_valA;
            dx_d.valB  = d_valB;
            dx_d.dstE  = dec_dstE;
            dx_d.dstM  = dec_dstM;
            dx_d.srcA  = dec_srcA;
            dx_d.srcB  = dec_srcB;
            dx_d.reqE  = req_e;
            dx_d.reqM  = req_m;
        end
    end

    // D->E pipeline register with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (reset) dx_q <= DX_BUBBLE;
        else       dx_q <= dx_d;
    end

    assign E_valid = dx_q.valid;
    assign E_icode = dx_q.icode;
    assign E_ifun  = dx_q.ifun;
    assign E_valC  = dx_q.valC;
    assign E_valA  = dx_q.valA;
    assign E_valB  = dx_q.valB;
    assign E_dstE  = dx_q.dstE;
    assign E_dstM  = dx_q.dstM;
    assign E_srcA  = dx_q.srcA;
    assign E_srcB  = dx_q.srcB;
    assign E_reqE  = dx_q.reqE;
    assign E_reqM  = dx_q.reqM;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage with a behavioural reference model.
module tb_decode_stage;
    localparam logic [2:0] ESP = 3'd4;

    logic        clk;
    logic        reset, f_valid, stall_in, bubble_in;
    logic [3:0]  f_icode, f_ifun;
    logic [2:0]  f_rA, f_rB, srcA, srcB;
    logic [31:0] f_valC, f_valP, rf_valA, rf_valB;
    logic [2:0]  e_dstE, m_dstM, M_dstE, W_dstM, W_dstE;
    logic        e_reqE, m_reqM, M_reqE, W_reqM, W_reqE;
    logic [31:0] e_valE, m_valM, M_valE, W_valM, W_valE;
    logic        d_stall, E_valid, E_reqE, E_reqM;
    logic [3:0]  E_icode, E_ifun;
    logic [31:0] E_valC, E_valA, E_valB;
    logic [2:0]  E_dstE, E_dstM, E_srcA, E_srcB;

    int   n_chk, n_err;
    logic chk_en;

    decode_stage #(.ESP_ID(ESP)) dut (
        .clk(clk), .reset(reset), .f_valid(f_valid), .f_icode(f_icode), .f_ifun(f_ifun),
        .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
        .stall_in(stall_in), .bubble_in(bubble_in), .srcA(srcA), .srcB(srcB),
        .rf_valA(rf_valA), .rf_valB(rf_valB),
        .e_dstE(e_dstE), .e_reqE(e_reqE), .e_valE(e_valE),
        .m_dstM(m_dstM), .m_reqM(m_reqM), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_reqE(M_reqE), .M_valE(M_valE),
        .W_dstM(W_dstM), .W_dstE(W_dstE), .W_reqM(W_reqM), .W_reqE(W_reqE),
        .W_valM(W_valM), .W_valE(W_valE), .d_stall(d_stall),
        .E_valid(E_valid), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB), .E_reqE(E_reqE), .E_reqM(E_reqM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected contents of the E register.
    logic        ms_valid, ms_reqE, ms_reqM;
    logic [3:0]  ms_icode, ms_ifun;
    logic [31:0] ms_valC, ms_valA, ms_valB;
    logic [2:0]  ms_dstE, ms_dstM, ms_srcA, ms_srcB;

    // Reference model: expected decode of the current fetch slot.
    logic        x_needA, x_needB, x_reqE, x_reqM, x_lu, x_haz, x_stall;
    logic [2:0]  x_srcA, x_srcB, x_dstE, x_dstM;
    logic [31:0] x_valA, x_valB;

`ifdef DECODE_FWD_EN
    function automatic logic [31:0] newest(input logic [2:0] src, input logic [31:0] rf);
        logic        req [5];
        logic [2:0]  dst [5];
        logic [31:0] val [5];
        logic [31:0] r;
        req = '{e_reqE, m_reqM, M_reqE, W_reqM, W_reqE};
        dst = '{e_dstE, m_dstM, M_dstE, W_dstM, W_dstE};
        val = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        r = rf;
        for (int i = 4; i >= 0; i--) if (req[i] && dst[i] == src) r = val[i];
        return r;
    endfunction
`else
    function automatic logic pending(input logic [2:0] src);
        logic       req [7];
        logic [2:0] dst [7];
        logic       r;
        req = '{e_reqE, m_reqM, M_reqE, W_reqM, W_reqE, ms_valid && ms_reqE, ms_valid && ms_reqM};
        dst = '{e_dstE, m_dstM, M_dstE, W_dstM, W_dstE, ms_dstE, ms_dstM};
        r = 1'b0;
        for (int i = 0; i < 7; i++) if (req[i] && dst[i] == src) r = 1'b1;
        return r;
    endfunction
`endif

    always_comb begin
        x_srcA = 3'd0;
        if (f_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) x_srcA = f_rA;
        if (f_icode inside {4'h9, 4'hB})             x_srcA = ESP;
        x_needA = f_valid && (f_icode inside {4'h2, 4'h4, 4'h6, 4'hA, 4'h9, 4'hB});
        x_srcB = 3'd0;
        if (f_icode inside {4'h4, 4'h5, 4'h6})       x_srcB = f_rB;
        if (f_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) x_srcB = ESP;
        x_needB = f_valid && (f_icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB});
        x_dstE = 3'd0;
        if (f_icode inside {4'h2, 4'h3, 4'h6})       x_dstE = f_rB;
        if (f_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) x_dstE = ESP;
        x_reqE = f_valid && (f_icode inside {4'h2, 4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB});
        x_dstM = (f_icode inside {4'h5, 4'hB}) ? f_rA : 3'd0;
        x_reqM = f_valid && (f_icode inside {4'h5, 4'hB});
        x_lu = ms_valid && ms_reqM && (ms_icode inside {4'h5, 4'hB}) &&
               ((x_needA && ms_dstM == x_srcA) || (x_needB && ms_dstM == x_srcB));
`ifdef DECODE_FWD_EN
        x_haz  = x_lu;
        x_valA = x_needA ? newest(x_srcA, rf_valA) : rf_valA;
        x_valB = x_needB ? newest(x_srcB, rf_valB) : rf_valB;
`else
        x_haz  = x_lu || (x_needA && pending(x_srcA)) || (x_needB && pending(x_srcB));
        x_valA = rf_valA;
        x_valB = rf_valB;
`endif
        if (f_icode inside {4'h7, 4'h8}) x_valA = f_valP;
        x_stall = !reset && x_haz;
    end

    // Model E register update.
    always @(posedge clk) begin
        if (reset || (!stall_in && (bubble_in || x_haz || !f_valid))) begin
            ms_valid <= 1'b0; ms_icode <= 4'h1; ms_ifun <= 4'h0;
            ms_valC <= 32'h0; ms_valA <= 32'h0; ms_valB <= 32'h0;
            ms_dstE <= 3'd0; ms_dstM <= 3'd0; ms_srcA <= 3'd0; ms_srcB <= 3'd0;
            ms_reqE <= 1'b0; ms_reqM <= 1'b0;
        end else if (!stall_in) begin
            ms_valid <= 1'b1; ms_icode <= f_icode; ms_ifun <= f_ifun;
            ms_valC <= f_valC; ms_valA <= x_valA; ms_valB <= x_valB;
            ms_dstE <= x_dstE; ms_dstM <= x_dstM; ms_srcA <= x_srcA; ms_srcB <= x_srcB;
            ms_reqE <= x_reqE; ms_reqM <= x_reqM;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("d_stall", 32'(d_stall), 32'(x_stall));
            if (f_valid) begin
                check("srcA", 32'(srcA), 32'(x_srcA));
                check("srcB", 32'(srcB), 32'(x_srcB));
            end
            check("E_valid", 32'(E_valid), 32'(ms_valid));
            check("E_icode", 32'(E_icode), 32'(ms_icode));
            check("E_ifun", 32'(E_ifun), 32'(ms_ifun));
            check("E_valC", E_valC, ms_valC);
            check("E_valA", E_valA, ms_valA);
            check("E_valB", E_valB, ms_valB);
            check("E_dstE", 32'(E_dstE), 32'(ms_dstE));
            check("E_dstM", 32'(E_dstM), 32'(ms_dstM));
            check("E_srcA", 32'(E_srcA), 32'(ms_srcA));
            check("E_srcB", 32'(E_srcB), 32'(ms_srcB));
            check("E_reqE", 32'(E_reqE), 32'(ms_reqE));
            check("E_reqM", 32'(E_reqM), 32'(ms_reqM));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [31:0] vc, input logic [31:0] vp);
        f_valid = 1'b1; f_icode = ic; f_ifun = 4'h0;
        f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
    endtask

    task automatic no_fwd();
        e_reqE = 1'b0; m_reqM = 1'b0; M_reqE = 1'b0; W_reqM = 1'b0; W_reqE = 1'b0;
        e_dstE = 3'd0; m_dstM = 3'd0; M_dstE = 3'd0; W_dstM = 3'd0; W_dstE = 3'd0;
        e_valE = 32'hE1; m_valM = 32'hA1; M_valE = 32'hB1; W_valM = 32'hC1; W_valE = 32'hD1;
    endtask

    initial begin
        n_chk = 0; n_err = 0; chk_en = 1'b0;
        reset = 1'b1; stall_in = 1'b0; bubble_in = 1'b0;
        no_fwd();
        rf_valA = 32'd5; rf_valB = 32'd7;
        fetch(4'h6, 3'd1, 3'd2, 32'h0, 32'h0);
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_E_valid", 32'(E_valid), 32'd0);
        check("rst_E_icode", 32'(E_icode), 32'd1);
        check("rst_E_valA", E_valA, 32'd0);
        check("rst_d_stall", 32'(d_stall), 32'd0);
        reset = 1'b0;

        // OPL rA=1 rB=2 straight from the register file
        tick();
        check("opl_valA", E_valA, 32'd5);
        check("opl_valB", E_valB, 32'd7);
        check("opl_dstE", 32'(E_dstE), 32'd2);
        check("opl_reqE", 32'(E_reqE), 32'd1);

        // Several in-flight writes to reg 3
        fetch(4'h6, 3'd3, 3'd6, 32'h0, 32'h0);
        rf_valA = 32'h99; rf_valB = 32'h77;
        e_reqE = 1'b1; e_dstE = 3'd3; e_valE = 32'h11;
        M_reqE = 1'b1; M_dstE = 3'd3; M_valE = 32'h22;
        W_reqE = 1'b1; W_dstE = 3'd3; W_valE = 32'h33;
`ifdef DECODE_FWD_EN
        @(negedge clk);
        check("fwd_no_stall", 32'(d_stall), 32'd0);
        tick();
        check("fwd_e", E_valA, 32'h11);
        check("fwd_rfB", E_valB, 32'h77);
        e_reqE = 1'b0;
        tick();
        check("fwd_M", E_valA, 32'h22);
        M_reqE = 1'b0; W_reqM = 1'b1; W_dstM = 3'd3; W_valM = 32'h44;
        tick();
        check("fwd_WM", E_valA, 32'h44);
        W_reqM = 1'b0;
        tick();
        check("fwd_WE", E_valA, 32'h33);
`else
        @(negedge clk);
        check("nofwd_stall", 32'(d_stall), 32'd1);
        tick();
        check("nofwd_bubble", 32'(E_valid), 32'd0);
        no_fwd();
        tick();
        check("nofwd_rf", E_valA, 32'h99);
        fetch(4'h6, 3'd1, 3'd7, 32'h0, 32'h0);
        W_reqE = 1'b1; W_dstE = 3'd1;
        @(negedge clk);
        check("nofwd_W_stall", 32'(d_stall), 32'd1);
        tick();
        check("nofwd_W_bubble", 32'(E_valid), 32'd0);
`endif
        no_fwd();
        f_valid = 1'b0;
        tick();

        // Load/use: MRMOVL rA=3 followed by OPL rA=3
        fetch(4'h5, 3'd3, 3'd0, 32'h8, 32'h0);
        rf_valB = 32'h1000;
        tick();
        check("ld_icode", 32'(E_icode), 32'h5);
        check("ld_dstM", 32'(E_dstM), 32'd3);
        check("ld_reqM", 32'(E_reqM), 32'd1);
        check("ld_valC", E_valC, 32'h8);
        check("ld_valB", E_valB, 32'h1000);
        fetch(4'h6, 3'd3, 3'd1, 32'h0, 32'h0);
        rf_valA = 32'hAA; rf_valB = 32'hBB;
        @(negedge clk);
        check("lu_stall", 32'(d_stall), 32'd1);
        tick();
        check("lu_bubble", 32'(E_valid), 32'd0);
        m_reqM = 1'b1; m_dstM = 3'd3; m_valM = 32'h5555;
`ifdef DECODE_FWD_EN
        @(negedge clk);
        check("lu_release", 32'(d_stall), 32'd0);
        tick();
        check("lu_valA_m", E_valA, 32'h5555);
        check("lu_valB", E_valB, 32'hBB);
`else
        @(negedge clk);
        check("lu_m_stall", 32'(d_stall), 32'd1);
        tick();
        check("lu_m_bubble", 32'(E_valid), 32'd0);
        no_fwd();
        rf_valA = 32'h5555;
        tick();
        check("lu_valA_rf", E_valA, 32'h5555);
`endif
        no_fwd();

        // CALL carries valP in valA and updates %esp
        fetch(4'h8, 3'd0, 3'd0, 32'h100, 32'h40);
        rf_valB = 32'h200;
        tick();
        check("call_valA", E_valA, 32'h40);
        check("call_srcB", 32'(E_srcB), 32'd4);
        check("call_dstE", 32'(E_dstE), 32'd4);
        check("call_reqE", 32'(E_reqE), 32'd1);
        f_valid = 1'b0;
        tick();

        // POPL rA=2
        fetch(4'hB, 3'd2, 3'd0, 32'h0, 32'h44);
        @(negedge clk);
        check("pop_srcA", 32'(srcA), 32'd4);
        check("pop_srcB", 32'(srcB), 32'd4);
        tick();
        check("pop_dstM", 32'(E_dstM), 32'd2);
        check("pop_reqM", 32'(E_reqM), 32'd1);
        check("pop_dstE", 32'(E_dstE), 32'd4);

        // stall_in holds E for three cycles; the last one also has a load/use
        fetch(4'h3, 3'd0, 3'd5, 32'h77, 32'h0);
        stall_in = 1'b1;
        repeat (2) begin
            tick();
            check("hold_icode", 32'(E_icode), 32'hB);
            check("hold_dstM", 32'(E_dstM), 32'd2);
        end
        fetch(4'h6, 3'd2, 3'd3, 32'h0, 32'h0);
        @(negedge clk);
        check("hold_lu_stall", 32'(d_stall), 32'd1);
        tick();
        check("hold_lu_icode", 32'(E_icode), 32'hB);
        stall_in = 1'b0;
        tick();
        check("after_hold_bubble", 32'(E_valid), 32'd0);
        tick();
        check("after_hold_issue", 32'(E_icode), 32'h6);

        // bubble_in
        fetch(4'h3, 3'd0, 3'd5, 32'h77, 32'h0);
        bubble_in = 1'b1;
        tick();
        check("bub_valid", 32'(E_valid), 32'd0);
        check("bub_icode", 32'(E_icode), 32'd1);
        bubble_in = 1'b0;
        tick();
        check("irm_icode", 32'(E_icode), 32'h3);
        check("irm_dstE", 32'(E_dstE), 32'd5);
        check("irm_valC", E_valC, 32'h77);

        // Empty fetch slot never stalls and loads a bubble
        fetch(4'h6, 3'd5, 3'd5, 32'h0, 32'h0);
        f_valid = 1'b0;
        @(negedge clk);
        check("inv_stall", 32'(d_stall), 32'd0);
        tick();
        check("inv_valid", 32'(E_valid), 32'd0);

        // Sweep every icode with assorted in-flight writes
        for (int ic = 0; ic < 12; ic++) begin
            fetch(4'(ic), 3'(ic), 3'(ic + 3), 32'(ic * 16), 32'(ic * 4 + 100));
            f_ifun  = 4'(ic % 4);
            rf_valA = 32'(ic + 1000);
            rf_valB = 32'(ic + 2000);
            e_reqE = (ic % 3 == 0); e_dstE = 3'(ic);     e_valE = 32'(ic + 3000);
            M_reqE = (ic % 2 == 0); M_dstE = 3'(ic + 3); M_valE = 32'(ic + 4000);
            W_reqM = 1'b1;          W_dstM = ESP;        W_valM = 32'(ic + 5000);
            tick();
            tick();
        end
        no_fwd();
        f_valid = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Y86 decode stage, between the fetch pipeline register and the execute stage. Derives register-file source/destination IDs from fetched fields, drives the register-file read ports, and forwards in-flight results. Detects load/use hazards and owns the D→E pipeline register that feeds execute.

## Interface
- Parameters: `ESP_ID`, default 3'd4, register ID of %esp.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `f_valid` in 1: fetched instruction present.
- `f_icode`, `f_ifun` in 4 each: instruction code and function.
- `f_rA`, `f_rB` in 3 each: register specifiers.
- `f_valC`, `f_valP` in 32 each: constant and next PC.
- `stall_in`, `bubble_in` in 1 each: pipeline control from hazard unit.
- `srcA`, `srcB` out 3 each: register-file read addresses.
- `rf_valA`, `rf_valB` in 32 each: register-file read data (combinational).
- `e_dstE` in 3, `e_reqE` in 1, `e_valE` in 32: execute-stage ALU result.
- `m_dstM` in 3, `m_reqM` in 1, `m_valM` in 32: memory-stage load data.
- `M_dstE` in 3, `M_reqE` in 1, `M_valE` in 32: memory-stage pipeline register.
- `W_dstM`, `W_dstE` in 3 each; `W_reqM`, `W_reqE` in 1 each; `W_valM`, `W_valE` in 32 each: writeback (regfile write) values.
- `d_stall` out 1: load/use stall request to fetch.
- `E_valid` out 1; `E_icode`, `E_ifun` out 4 each; `E_valC`, `E_valA`, `E_valB` out 32 each; `E_dstE`, `E_dstM`, `E_srcA`, `E_srcB` out 3 each; `E_reqE`, `E_reqM` out 1 each: D→E register.

## Operation
- Icodes: HALT 0, NOP 1, RRMOVL 2, IRMOVL 3, RMMOVL 4, MRMOVL 5, OPL 6, JXX 7, CALL 8, RET 9, PUSHL A, POPL B.
- Source A, with needA: rA for 2, 4, 6, A. `ESP_ID` for 9, B. Otherwise needA=0 and srcA=0.
- Source B, with needB: rB for 4, 5, 6. `ESP_ID` for 8, 9, A, B. Otherwise needB=0 and srcB=0.
- dstE, with reqE: rB for 2, 3, 6. `ESP_ID` for 8, 9, A, B.
- dstM, with reqM: rA for 5, B.
- All req/need flags are forced to 0 when `f_valid`=0.
- d_valA:
  - f_valP for CALL and JXX.
  - Otherwise, for needA, the first match of srcA in this priority: e_dstE/e_reqE, m_dstM/m_reqM, M_dstE/M_reqE, W_dstM/W_reqM, W_dstE/W_reqE, then rf_valA.
- d_valB: same priority chain on srcB, with no valP case.
- Load/use hazard: E_valid and E_reqM and E_icode∈{5,B} and E_dstM matches srcA (needA) or srcB (needB). When it holds, `d_stall`=1.
- D→E register update, in priority order:
  1. reset: bubble.
  2. stall_in: hold.
  3. bubble_in or load/use: bubble.
  4. Otherwise, load decoded fields.
- Bubble value: E_valid=0, E_icode=1 (NOP), every other E_* field 0.
- E_valA/E_valB capture d_valA/d_valB.

## Timing
- Decode is combinational from f_* to srcA/srcB/d_stall; the E_* outputs have one-cycle latency.
- Reset value of every E_* output is the bubble value; d_stall=0 during reset.
- The register file writes at the clock edge. The W forwarding path covers same-cycle read-after-write, so rf data is never relied on for a W-stage destination.
- Simultaneous stall_in and load/use: hold wins. d_stall remains asserted.
- f_valid=0: a bubble-equivalent is loaded and d_stall=0.

## Configuration
- `DECODE_FWD_EN` defined: the forwarding network operates as above.
- `DECODE_FWD_EN` not defined:
  - d_valA/d_valB come directly from rf_valA/rf_valB, with f_valP still used for CALL/JXX.
  - The hazard condition widens: d_stall=1 and a bubble is inserted while any of (e_reqE,e_dstE), (m_reqM,m_dstM), (M_reqE,M_dstE), (W_reqM,W_dstM), (W_reqE,W_dstE), or the E-register dstE/dstM matches a needed source.

## Test plan
- Reset: hold reset 2 cycles with f_valid=1 → E_valid=0, E_icode=1, E_valA=0, d_stall=0.
- OPL rA=1 rB=2, rf_valA=5, rf_valB=7, no forwarding hits → next cycle E_valA=5, E_valB=7, E_dstE=2, E_reqE=1.
- Forward priority: srcA=3 with e_valE=0x11 (e_reqE), M_valE=0x22, W_valE=0x33 all targeting reg 3 → E_valA=0x11. Drop e_reqE → 0x22.
- Load/use: MRMOVL rA=3 enters E, then OPL rA=3 → d_stall=1 for one cycle, a bubble is loaded, and OPL issues the next cycle with E_valA=m_valM.
- CALL with f_valP=0x40 → E_valA=0x40, E_srcB=4, E_dstE=4. POPL → srcA=srcB=4, E_dstM=rA.
- stall_in=1 for 3 cycles after a load → E_* unchanged. With `DECODE_FWD_EN` off, W_reqE to reg 1 with OPL rA=1 → d_stall=1.
